// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock/strobe divider. Each channel has a
// run-time divisor that is swapped in only at a period boundary, and a shared sync restarts all channels in phase.
module clk_div_prog #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DIV_DEFAULT = 8,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                sclr,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_div,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] stb,
    output logic [CHANNELS-1:0] pend,
    output logic                wr_err
);
    localparam logic [CH_W:0]    LP_CH_LIM  = (CH_W+1)'(CHANNELS);
    localparam logic [WIDTH-1:0] LP_DIV_DEF = WIDTH'(DIV_DEFAULT);
    localparam logic [WIDTH-1:0] LP_DIV_MIN = WIDTH'(2);
    localparam logic [WIDTH-1:0] LP_ONE     = WIDTH'(1);

    // Length of the high phase: ceil(D/2), so odd divisors put the extra cycle high.
    function automatic logic [WIDTH-1:0] hi_len(input logic [WIDTH-1:0] d);
        return d - (d >> 1);
    endfunction

    logic [WIDTH-1:0]    r_cnt      [CHANNELS];
    logic [WIDTH-1:0]    r_act_div  [CHANNELS];
    logic [WIDTH-1:0]    r_pend_div [CHANNELS];
    logic [CHANNELS-1:0] r_pend_valid;
    logic [CHANNELS-1:0] r_clk_out;
    logic [CHANNELS-1:0] r_stb;
    logic                r_wr_err;

    logic                w_wr_ok;
    logic [CHANNELS-1:0] w_wr_hit;
    logic [CHANNELS-1:0] w_run;
    logic [CHANNELS-1:0] w_bound;
    logic [CHANNELS-1:0] w_apply;

    always_comb begin
        w_wr_ok  = wr_en && ({1'b0, wr_ch} < LP_CH_LIM) && (wr_div >= LP_DIV_MIN);
        w_wr_hit = '0;
        w_run    = '0;
        w_bound  = '0;
        w_apply  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_wr_hit[i] = w_wr_ok && (wr_ch == CH_W'(i));
            w_run[i]    = en[i] && !sync;
            w_bound[i]  = w_run[i] && (r_cnt[i] == r_act_div[i] - LP_ONE);
            // A pending divisor lands at a boundary, or at once while idle/syncing.
            w_apply[i]  = r_pend_valid[i] && (!w_run[i] || w_bound[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (sclr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i]     <= '0;
                r_act_div[i] <= LP_DIV_DEF;
            end
            r_pend_valid <= '0;
            r_clk_out    <= '0;
            r_stb        <= '0;
            r_wr_err     <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_run[i]) begin
                    r_clk_out[i] <= (r_cnt[i] < hi_len(r_act_div[i]));
                    r_stb[i]     <= (r_cnt[i] == '0);
                    r_cnt[i]     <= w_bound[i] ? '0 : r_cnt[i] + LP_ONE;
                end else begin
                    r_clk_out[i] <= 1'b0;
                    r_stb[i]     <= 1'b0;
                    r_cnt[i]     <= '0;
                end
                if (w_apply[i]) begin
                    r_act_div[i] <= r_pend_div[i];
                end
                // A same-edge write survives the load of the older value.
                if (w_wr_hit[i]) begin
                    r_pend_valid[i] <= 1'b1;
                end else if (w_apply[i]) begin
                    r_pend_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Divisor payload only matters while pend_valid is set, so it carries no reset.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_wr_hit[i]) begin
                r_pend_div[i] <= wr_div;
            end
        end
    end

    assign clk_out = r_clk_out;
    assign stb     = r_stb;
    assign pend    = r_pend_valid;
    assign wr_err  = r_wr_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: per-channel queue-of-periods reference model checked every
// cycle, a write-vector table, and hand-written corner-case sequences.
module tb_clk_div_prog;
    localparam int CHN = 5;
    localparam int WID = 8;
    localparam int DEF = 8;
    localparam int CW  = 3;

    logic           clk_in = 1'b0;
    logic           sclr;
    logic [CHN-1:0] en;
    logic           sync;
    logic           wr_en;
    logic [CW-1:0]  wr_ch;
    logic [WID-1:0] wr_div;
    logic [CHN-1:0] clk_out;
    logic [CHN-1:0] stb;
    logic [CHN-1:0] pend;
    logic           wr_err;

    always #5 clk_in = ~clk_in;

    clk_div_prog #(.CHANNELS(CHN), .WIDTH(WID), .DIV_DEFAULT(DEF), .CH_W(CW)) dut (
        .clk_in(clk_in), .sclr(sclr), .en(en), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .clk_out(clk_out), .stb(stb), .pend(pend), .wr_err(wr_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each running channel holds a queue of the exact
    // {clk,stb} samples still to be emitted in its current period.
    int             m_act  [CHN];
    int             m_pdiv [CHN];
    bit             m_pv   [CHN];
    bit [1:0]       m_q    [CHN][$];
    logic [CHN-1:0] e_clk, e_stb, e_pend;
    logic           e_err;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push_period(int i);
        int d;
        d = m_act[i];
        for (int k = 0; k < d; k++) begin
            m_q[i].push_back({bit'(k < d - d / 2), bit'(k == 0)});
        end
    endtask

    task automatic model_edge();
        bit       ok;
        bit [1:0] v;
        ok = wr_en && (int'(wr_ch) < CHN) && (int'(wr_div) >= 2);
        if (sclr) begin
            for (int i = 0; i < CHN; i++) begin
                m_act[i] = DEF;
                m_pv[i]  = 1'b0;
                m_q[i].delete();
            end
            e_clk = '0; e_stb = '0; e_pend = '0; e_err = 1'b0;
            return;
        end
        for (int i = 0; i < CHN; i++) begin
            if (sync || !en[i]) begin
                m_q[i].delete();
                if (m_pv[i]) begin m_act[i] = m_pdiv[i]; m_pv[i] = 1'b0; end
                e_clk[i] = 1'b0;
                e_stb[i] = 1'b0;
            end else begin
                if (m_q[i].size() == 0) push_period(i);
                v = m_q[i].pop_front();
                e_clk[i] = v[1];
                e_stb[i] = v[0];
                if (m_q[i].size() == 0 && m_pv[i]) begin
                    m_act[i] = m_pdiv[i];
                    m_pv[i]  = 1'b0;
                end
            end
            if (ok && int'(wr_ch) == i) begin
                m_pdiv[i] = int'(wr_div);
                m_pv[i]   = 1'b1;
            end
            e_pend[i] = m_pv[i];
        end
        e_err = wr_en && !ok;
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        chk("clk_out", clk_out, e_clk);
        chk("stb", stb, e_stb);
        chk("pend", pend, e_pend);
        chk("wr_err", wr_err, e_err);
    endtask

    task automatic measure(input int c, input int n, output int hi, output int ns);
        hi = 0;
        ns = 0;
        for (int k = 0; k < n; k++) begin
            hi += int'(clk_out[c]);
            ns += int'(stb[c]);
            step();
        end
    endtask

    task automatic write(input int ch, input int div);
        wr_en  = 1'b1;
        wr_ch  = CW'(ch);
        wr_div = WID'(div);
        step();
        wr_en  = 1'b0;
    endtask

    typedef struct {
        logic [CW-1:0]  ch;
        logic [WID-1:0] div;
        logic           err;
    } wr_vec_t;

    wr_vec_t tbl [6];

    initial begin
        int hi, ns, k, co;
        tbl[0] = '{3'd1, 8'd1, 1'b1};
        tbl[1] = '{3'd1, 8'd0, 1'b1};
        tbl[2] = '{3'd5, 8'd4, 1'b1};
        tbl[3] = '{3'd7, 8'd9, 1'b1};
        tbl[4] = '{3'd0, 8'd4, 1'b0};
        tbl[5] = '{3'd2, 8'd6, 1'b0};

        sclr = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        step();
        step();
        chk("rst_clk", clk_out, 0);
        chk("rst_stb", stb, 0);
        chk("rst_pend", pend, 0);
        chk("rst_err", wr_err, 0);

        // Default divisor: first stb right after enable, 4 high / 4 low
        sclr = 1'b0;
        en   = '1;
        step();
        chk("first_stb", stb, 32'h1f);
        measure(0, 16, hi, ns);
        chk("def_hi", hi, 8);
        chk("def_stb", ns, 2);

        // Mid-period write: pending until the 8-cycle period ends, then 3/2
        step();
        step();
        write(1, 5);
        chk("ch1_pend_set", pend[1], 1);
        k = 0;
        while (pend[1] && k < 12) begin step(); k++; end
        chk("ch1_pend_clear", pend[1], 0);
        k = 0;
        while (!stb[1] && k < 12) begin step(); k++; end
        chk("ch1_stb_seen", stb[1], 1);
        measure(1, 10, hi, ns);
        chk("ch1_hi", hi, 6);
        chk("ch1_stb", ns, 2);

        // Write vector table: rejected writes pulse wr_err for exactly one cycle
        for (int t = 0; t < 6; t++) begin
            write(int'(tbl[t].ch), int'(tbl[t].div));
            chk("tbl_err", wr_err, tbl[t].err);
            step();
            chk("tbl_err_clr", wr_err, 0);
        end

        // Knock ch2 out of phase, then sync: both low, then rise together
        k = 0;
        while ((pend[0] || pend[2]) && k < 20) begin step(); k++; end
        chk("ch02_applied", {pend[2], pend[0]}, 0);
        en[2] = 1'b0;
        repeat (3) step();
        en[2] = 1'b1;
        repeat (20) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_low", {clk_out[2], clk_out[0], stb[2], stb[0]}, 0);
        step();
        chk("sync_rise", {clk_out[2], clk_out[0], stb[2], stb[0]}, 4'hf);
        co = 0;
        for (int c = 0; c < 24; c++) begin
            co += int'(stb[0] && stb[2]);
            step();
        end
        chk("sync_coincide", co, 2);

        // Two writes before the boundary: only the last one takes effect
        write(3, 7);
        write(3, 3);
        k = 0;
        while (pend[3] && k < 12) begin step(); k++; end
        chk("ch3_pend_clear", pend[3], 0);
        k = 0;
        while (!stb[3] && k < 12) begin step(); k++; end
        measure(3, 6, hi, ns);
        chk("ch3_hi", hi, 4);
        chk("ch3_stb", ns, 2);

        // Write landing on the boundary edge stays pending for the next one
        k = 0;
        while (m_q[3].size() != 1 && k < 10) begin step(); k++; end
        chk("ch3_boundary_found", m_q[3].size(), 1);
        write(3, 4);
        chk("ch3_same_edge_pend", pend[3], 1);
        k = 0;
        while (pend[3] && k < 8) begin step(); k++; end
        chk("ch3_same_edge_clear", pend[3], 0);

        // Extremes on ch4: D=2 toggles, D=255 gives 128 high / 127 low
        write(4, 2);
        k = 0;
        while (pend[4] && k < 12) begin step(); k++; end
        k = 0;
        while (!stb[4] && k < 4) begin step(); k++; end
        measure(4, 8, hi, ns);
        chk("d2_hi", hi, 4);
        chk("d2_stb", ns, 4);
        write(4, 255);
        k = 0;
        while (pend[4] && k < 4) begin step(); k++; end
        chk("dmax_applied", pend[4], 0);
        k = 0;
        while (!stb[4] && k < 4) begin step(); k++; end
        measure(4, 255, hi, ns);
        chk("dmax_hi", hi, 128);
        chk("dmax_stb", ns, 1);

        // sclr mid-high-phase with a divisor pending: all cleared, default restored
        repeat (10) step();
        write(0, 3);
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        chk("sclr_clk", clk_out, 0);
        chk("sclr_pend", pend, 0);
        step();
        measure(4, 16, hi, ns);
        chk("sclr_def_hi", hi, 8);
        chk("sclr_def_stb", ns, 2);
        measure(0, 16, hi, ns);
        chk("sclr_ch0_def_hi", hi, 8);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < CHN; b++) begin
                if ($urandom_range(0, 39) == 0) en[b] = ~en[b];
            end
            sync  = ($urandom_range(0, 99) == 0);
            sclr  = ($urandom_range(0, 499) == 0);
            wr_en = ($urandom_range(0, 7) == 0);
            wr_ch = CW'($urandom_range(0, 7));
            wr_div = ($urandom_range(0, 15) == 0) ? WID'(255) : WID'($urandom_range(0, 12));
            step();
        end
        sclr = 1'b0; sync = 1'b0; wr_en = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
